// File: rtl/core_pkg.sv
// Shared core definitions: FSM state codes, x0 index, NOP encoding
// and the pipeline control bundle used by the stall controller.
package core_pkg;

    localparam logic ST_RUN      = 1'b0;
    localparam logic ST_MEM_WAIT = 1'b1;

    localparam logic [4:0]  REG_X0   = 5'd0;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic {
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT
    } stall_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exma_en;
        logic mawb_en;
    } stall_ctrl_t;

    localparam stall_ctrl_t CTRL_RUN    = 7'b110_1011;
    localparam stall_ctrl_t CTRL_FREEZE = 7'b000_0000;
    localparam stall_ctrl_t CTRL_BRANCH = 7'b111_1111;
    localparam stall_ctrl_t CTRL_LDUSE  = 7'b000_1111;
    localparam stall_ctrl_t CTRL_RESET  = 7'b111_1111;

    function automatic logic load_use(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] rd,
        input logic       memread,
        input logic       regwen
    );
        logic w_match;
        w_match = (use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd));
        return memread && regwen && (rd != REG_X0) && w_match;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline-register controls of the stall controller.
// master: core top level (drives hazard info); slave: the controller.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic [4:0]       rd_ex;
    logic             memread_ex;
    logic             regwen_ex;
    logic             br_taken_ex;
    logic             dmem_req_ma;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exma_en;
    logic             mawb_en;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        output rd_ex, memread_ex, regwen_ex, br_taken_ex,
        output dmem_req_ma, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        input  exma_en, mawb_en, mem_timeout, stall_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id,
        input  rd_ex, memread_ex, regwen_ex, br_taken_ex,
        input  dmem_req_ma, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        output exma_en, mawb_en, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Ports: clk, reset_n, inc (count enable), count (never wraps).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller: load-use bubble, branch squash, dmem freeze
// with timeout. Ports: clk, reset_n (sync, active-low), bus (slave).
module pipeline_stall_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    pipeline_stall_ctrl_if.slave bus
);
    localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

    stall_state_e r_state;
    stall_state_e w_state_nxt;
    logic [15:0]  r_wcnt;
    logic [15:0]  w_wcnt_nxt;
    logic         r_mem_timeout;
    logic         w_timeout;
    logic         w_lu;
    logic         w_mw;
    stall_ctrl_t  w_ctrl;

    assign w_lu = load_use(bus.rs1_id, bus.rs2_id,
                           bus.use_rs1_id, bus.use_rs2_id,
                           bus.rd_ex, bus.memread_ex, bus.regwen_ex);
    assign w_mw = bus.dmem_req_ma && !bus.dmem_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_RUN;
            r_wcnt        <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wcnt        <= w_wcnt_nxt;
            r_mem_timeout <= w_timeout;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_timeout   = 1'b0;
        w_ctrl      = CTRL_RUN;
        unique case (r_state)
            S_RUN: begin
                if (w_mw) begin
                    w_ctrl      = CTRL_FREEZE;
                    w_state_nxt = S_MEM_WAIT;
                    w_wcnt_nxt  = 16'd1;
                end else if (bus.br_taken_ex) begin
                    // Squash wins: the dependent insn dies anyway.
                    w_ctrl = CTRL_BRANCH;
                end else if (w_lu) begin
                    w_ctrl = CTRL_LDUSE;
                end
            end
            S_MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    w_state_nxt = S_RUN;
                    w_wcnt_nxt  = '0;
                end else if (r_wcnt == WCNT_LAST) begin
                    // Abort: release now, trap path sees the pulse.
                    w_state_nxt = S_RUN;
                    w_wcnt_nxt  = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_ctrl     = CTRL_FREEZE;
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
        // Reset fills every stage with NOPs.
        if (!reset_n) begin
            w_ctrl = CTRL_RESET;
        end
    end

    assign bus.pc_en       = w_ctrl.pc_en;
    assign bus.ifid_en     = w_ctrl.ifid_en;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_en     = w_ctrl.idex_en;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.exma_en     = w_ctrl.exma_en;
    assign bus.mawb_en     = w_ctrl.mawb_en;
    assign bus.mem_timeout = r_mem_timeout;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (!w_ctrl.pc_en && reset_n),
        .count  (bus.stall_cnt)
    );
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Per-cycle expectations go through a scoreboard queue.
module tb_pipeline_stall_ctrl;

    logic clk;
    logic reset_n;

    pipeline_stall_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       rw;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic [3:0] cnt;
        logic       to;
    } exp_t;

    localparam logic [6:0] C_RUN = 7'b110_1011;
    localparam logic [6:0] C_LU  = 7'b000_1111;
    localparam logic [6:0] C_BR  = 7'b111_1111;
    localparam logic [6:0] C_FRZ = 7'b000_0000;
    localparam logic [6:0] C_RST = 7'b111_1111;

    exp_t sb[$];
    int   checks;
    int   failures;

    logic [6:0] w_obs;
    assign w_obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush,
                    bus.idex_en, bus.idex_flush,
                    bus.exma_en, bus.mawb_en};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s      = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    function automatic stim_t lu1(input logic [4:0] r);
        stim_t s;
        s     = idle();
        s.mr  = 1'b1;
        s.rw  = 1'b1;
        s.rd  = r;
        s.rs1 = r;
        s.u1  = 1'b1;
        return s;
    endfunction

    function automatic stim_t memw(input logic rdy);
        stim_t s;
        s     = idle();
        s.req = 1'b1;
        s.rdy = rdy;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset_n         = s.rstn;
        bus.rs1_id      = s.rs1;
        bus.rs2_id      = s.rs2;
        bus.use_rs1_id  = s.u1;
        bus.use_rs2_id  = s.u2;
        bus.rd_ex       = s.rd;
        bus.memread_ex  = s.mr;
        bus.regwen_ex   = s.rw;
        bus.br_taken_ex = s.br;
        bus.dmem_req_ma = s.req;
        bus.dmem_ready  = s.rdy;
    endtask

    task automatic cyc(input string      tag,
                       input stim_t      s,
                       input logic [6:0] ec,
                       input logic [3:0] ecnt,
                       input logic       eto);
        exp_t e;
        exp_t o;
        @(negedge clk);
        apply(s);
        e.tag  = tag;
        e.ctrl = ec;
        e.cnt  = ecnt;
        e.to   = eto;
        sb.push_back(e);
        #1;
        o = sb.pop_front();
        check({o.tag, ".ctrl"}, 32'(w_obs), 32'(o.ctrl));
        check({o.tag, ".cnt"}, 32'(bus.stall_cnt), 32'(o.cnt));
        check({o.tag, ".to"}, 32'(bus.mem_timeout), 32'(o.to));
    endtask

    initial begin
        stim_t s;
        checks   = 0;
        failures = 0;
        s        = idle();
        s.rstn   = 1'b0;
        apply(s);
        repeat (2) @(posedge clk);

        cyc("reset", s, C_RST, 4'd0, 1'b0);
        cyc("idle", idle(), C_RUN, 4'd0, 1'b0);
        cyc("lu_rs1", lu1(5'd5), C_LU, 4'd0, 1'b0);
        cyc("lu_after", idle(), C_RUN, 4'd1, 1'b0);
        cyc("lu_x0", lu1(5'd0), C_RUN, 4'd1, 1'b0);

        s      = lu1(5'd7);
        s.u1   = 1'b0;
        s.rs1  = 5'd0;
        s.rs2  = 5'd7;
        s.u2   = 1'b1;
        cyc("lu_rs2", s, C_LU, 4'd1, 1'b0);
        s      = lu1(5'd9);
        s.u1   = 1'b0;
        cyc("lu_nouse", s, C_RUN, 4'd2, 1'b0);
        s      = lu1(5'd9);
        s.rw   = 1'b0;
        cyc("lu_nowen", s, C_RUN, 4'd2, 1'b0);
        s      = lu1(5'd5);
        s.br   = 1'b1;
        cyc("br_over_lu", s, C_BR, 4'd2, 1'b0);
        cyc("br_after", idle(), C_RUN, 4'd2, 1'b0);

        cyc("mw1", memw(1'b0), C_FRZ, 4'd2, 1'b0);
        s      = lu1(5'd5);
        s.br   = 1'b1;
        s.req  = 1'b1;
        cyc("mw2_ign", s, C_FRZ, 4'd3, 1'b0);
        cyc("mw3", memw(1'b0), C_FRZ, 4'd4, 1'b0);
        cyc("mw_rel", memw(1'b1), C_RUN, 4'd5, 1'b0);
        cyc("mw_post", idle(), C_RUN, 4'd5, 1'b0);
        s      = idle();
        s.rdy  = 1'b1;
        cyc("rdy_noreq", s, C_RUN, 4'd5, 1'b0);

        cyc("to1", memw(1'b0), C_FRZ, 4'd5, 1'b0);
        cyc("to2", memw(1'b0), C_FRZ, 4'd6, 1'b0);
        cyc("to3", memw(1'b0), C_FRZ, 4'd7, 1'b0);
        cyc("to_rel", memw(1'b0), C_RUN, 4'd8, 1'b0);
        cyc("to_pulse", lu1(5'd5), C_LU, 4'd8, 1'b1);
        cyc("to_end", idle(), C_RUN, 4'd9, 1'b0);

        cyc("rw1", memw(1'b0), C_FRZ, 4'd9, 1'b0);
        s      = memw(1'b0);
        s.rstn = 1'b0;
        cyc("rw_rst", s, C_RST, 4'd10, 1'b0);
        cyc("rw_run", lu1(5'd5), C_LU, 4'd0, 1'b0);
        cyc("rw_idle", idle(), C_RUN, 4'd1, 1'b0);
        cyc("rw_nopulse", idle(), C_RUN, 4'd1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            cyc("sat", lu1(5'd5), C_LU,
                4'((k + 1 > 15) ? 15 : k + 1), 1'b0);
        end
        cyc("sat_hold", idle(), C_RUN, 4'd15, 1'b0);
        s      = idle();
        s.rstn = 1'b0;
        cyc("sat_rst", s, C_RST, 4'd15, 1'b0);
        cyc("sat_clr", idle(), C_RUN, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
